dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Sequences and shares the single-port data memory (2**addr_bus x data_size, combinational read, write on Wr) between the CPU datapath and the debug/UART dump path.
- Contains a sequential clear engine that zeroes every word one address per cycle, replacing any combinational bulk clear.
- Sits between the CPU core, the debug unit and the data memory; it is the only driver of the memory's Rd/Wr/Addr/In_Data.

Parameters:
- addr_bus, 11, memory address width; depth = 2**addr_bus.
- data_size, 16, memory word width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  reset Reset, synchronous, active-high.
- Cpu_Req  in  1  CPU access request (held for one cycle per access).
- Cpu_Wr  in  1  1 = write, 0 = read; valid with Cpu_Req.
- Cpu_Addr  in  addr_bus  CPU address.
- Cpu_Wdata  in  data_size  CPU write data.
- Cpu_Ack  out  1  combinational grant; access happens this cycle.
- Cpu_Rdata  out  data_size  read data, valid when Cpu_Ack && !Cpu_Wr, else 0.
- Clr_Start  in  1  pulse: start full-memory clear.
- Clr_Busy  out  1  clear in progress.
- Dbg_Start  in  1  pulse: start dump burst.
- Dbg_Base  in  addr_bus  first dump address.
- Dbg_Len  in  addr_bus+1  word count, 0..2**addr_bus.
- Dbg_Data  out  data_size  dumped word (registered).
- Dbg_Valid  out  1  Dbg_Data valid.
- Dbg_Ready  in  1  consumer accepts word when Dbg_Valid && Dbg_Ready.
- Dbg_Done  out  1  one-cycle pulse after last word accepted.
- Mem_Rd, Mem_Wr  out  1 each  memory strobes.
- Mem_Addr  out  addr_bus  memory address.
- Mem_Wdata  out  data_size  memory write data.
- Mem_Rdata  in  data_size  memory read data (same cycle).

Behaviour:
- Reset: state IDLE; Cpu_Ack, Clr_Busy, Dbg_Valid, Dbg_Done, Mem_Rd, Mem_Wr = 0; Dbg_Data, Mem_Addr, Mem_Wdata = 0; counters cleared. Memory contents are not touched by Reset.
- FSM states: IDLE, CLEAR, DUMP.
- IDLE -> CLEAR on Clr_Start. Clr_Start has priority over a simultaneous Dbg_Start, which is dropped.
- IDLE -> DUMP on Dbg_Start with Dbg_Len != 0. Dbg_Start with Dbg_Len == 0 pulses Dbg_Done next cycle and stays IDLE.
- Start pulses arriving outside IDLE are ignored.
- CLEAR:
  - Mem_Wr = 1, Mem_Wdata = 0, Mem_Addr = clear counter, starting at 0.
  - Takes exactly 2**addr_bus cycles and covers every address including 2**addr_bus-1.
  - Clr_Busy = 1 throughout; Cpu_Ack = 0, so the CPU stalls.
  - Returns to IDLE the cycle after the last address; Clr_Busy drops then.
- CPU access, in IDLE or DUMP:
  - Cpu_Ack = Cpu_Req, zero-latency.
  - Mem_Rd = !Cpu_Wr, Mem_Wr = Cpu_Wr, Mem_Addr = Cpu_Addr, Mem_Wdata = Cpu_Wdata.
  - The CPU always wins over the dump path in the same cycle.
- DUMP:
  - Fetch when !Cpu_Req and the output register is free (Dbg_Valid == 0, or Dbg_Valid && Dbg_Ready this cycle).
  - On fetch: Mem_Rd = 1, Mem_Addr = fetch pointer; Dbg_Data <= Mem_Rdata, Dbg_Valid <= 1; pointer +1 (mod 2**addr_bus, wraps from 2047 to 0); remaining count -1.
  - Dbg_Data is held stable while Dbg_Valid && !Dbg_Ready.
  - After the last word is accepted: Dbg_Valid <= 0, Dbg_Done pulses one cycle, state -> IDLE.
  - Sustained throughput is one word per cycle when Dbg_Ready = 1 and there are no CPU requests.
- When no access is active, Mem_Rd = Mem_Wr = 0 and Cpu_Rdata = 0.
- Reset mid-CLEAR or mid-DUMP: abort immediately to IDLE with reset outputs. The partial clear is left as is.

Optional Feature:
- DMEM_ARB_DUMP_CHECKSUM_EN defined:
  - Adds output Dbg_Checksum [data_size-1:0].
  - Holds the modulo-2**data_size sum of words accepted in the current burst.
  - Cleared on the accepted Dbg_Start; stable from Dbg_Done until the next start; 0 on Reset.
- Undefined: port and adder are absent; behaviour otherwise identical.

Decomposition:
- Package dmem_arb_pkg: FSM state encoding (IDLE/CLEAR/DUMP) and source-select encoding for the memory mux (NONE/CPU/CLR/DBG).
- One natural sub-module, dmem_dump_engine: fetch pointer, remaining counter, output register, valid/ready logic and optional checksum.
- The top level keeps the FSM, clear counter and memory mux.

Test Plan:
- Reset, then Cpu_Req=1, Cpu_Wr=1, Addr=0x005, Wdata=0xBEEF, followed by a CPU read of 0x005 -> Cpu_Ack=1 both cycles, Cpu_Rdata=0xBEEF.
- Preload 0x7FF=0x1234 and 0x000=0x5678; Clr_Start -> Clr_Busy high exactly 2048 cycles; CPU requests get Cpu_Ack=0 throughout; afterwards reads of 0x000 and 0x7FF return 0.
- Preload 0x7FE..0x7FF and 0x000 with 1, 2, 3; Dbg_Base=0x7FE, Dbg_Len=3, Dbg_Ready=1 -> Dbg_Data sequence 1, 2, 3 on consecutive cycles (wrap 0x7FF->0x000); Dbg_Done one cycle after the third accept; checksum=6 when enabled.
- Dump with Len=4 while Dbg_Ready toggles 1,0,0,1 and Cpu_Req is asserted mid-burst -> CPU acked same cycle; Dbg_Data held while not ready; no word lost or duplicated.
- Clr_Start and Dbg_Start in the same cycle -> CLEAR runs, no Dbg_Valid, no Dbg_Done; Dbg_Start with Len=0 in IDLE -> Dbg_Done next cycle, no memory read.
- Reset asserted 100 cycles into CLEAR -> next cycle Clr_Busy=0 and state IDLE; addresses 0..99 read 0, address 100 keeps its old value.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and memory-mux source select.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DUMP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_CLR  = 2'd2,
    SRC_DBG  = 2'd3
  } mem_src_e;

endpackage

// File: rtl/dmem_dump_engine.sv
// Debug dump burst engine: fetch pointer, remaining count, registered output with valid/ready.
// Optional running checksum of accepted words when DMEM_ARB_DUMP_CHECKSUM_EN is defined.
module dmem_dump_engine
  import dmem_arb_pkg::*;
#(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 active,
  input  logic                 cpu_req,
  input  logic [addr_bus-1:0]  base,
  input  logic [addr_bus:0]    len,
  input  logic [data_size-1:0] mem_rdata,
  input  logic                 dbg_ready,
  output logic                 fetch,
  output logic [addr_bus-1:0]  fetch_addr,
  output logic [data_size-1:0] dbg_data,
  output logic                 dbg_valid,
  output logic                 dbg_done,
  output logic                 last_acc
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
  , output logic [data_size-1:0] dbg_checksum
`endif
);

  logic [addr_bus-1:0]  ptr_q, ptr_d;
  logic [addr_bus:0]    rem_q, rem_d;
  logic [data_size-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 accept;

  assign accept     = valid_q && dbg_ready;
  // The CPU owns the port whenever it requests; the output register must be free to refill.
  assign fetch      = active && !cpu_req && (rem_q != '0) && (!valid_q || dbg_ready);
  assign last_acc   = active && accept && (rem_q == '0);
  assign fetch_addr = ptr_q;
  assign dbg_data   = data_q;
  assign dbg_valid  = valid_q;
  assign dbg_done   = done_q;

  always_comb begin
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = (start && (len == '0)) || last_acc;
    if (start) begin
      ptr_d = base;
      rem_d = len;
    end
    if (fetch) begin
      ptr_d   = ptr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
      data_d  = mem_rdata;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
  logic [data_size-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start)       sum_d = '0;
    else if (accept) sum_d = sum_q + data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign dbg_checksum = sum_q;
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: CPU access, sequential clear engine and debug dump path.
// Define DMEM_ARB_DUMP_CHECKSUM_EN to add the Dbg_Checksum output.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Cpu_Req,
  input  logic                 Cpu_Wr,
  input  logic [addr_bus-1:0]  Cpu_Addr,
  input  logic [data_size-1:0] Cpu_Wdata,
  output logic                 Cpu_Ack,
  output logic [data_size-1:0] Cpu_Rdata,
  input  logic                 Clr_Start,
  output logic                 Clr_Busy,
  input  logic                 Dbg_Start,
  input  logic [addr_bus-1:0]  Dbg_Base,
  input  logic [addr_bus:0]    Dbg_Len,
  output logic [data_size-1:0] Dbg_Data,
  output logic                 Dbg_Valid,
  input  logic                 Dbg_Ready,
  output logic                 Dbg_Done,
  output logic                 Mem_Rd,
  output logic                 Mem_Wr,
  output logic [addr_bus-1:0]  Mem_Addr,
  output logic [data_size-1:0] Mem_Wdata,
  input  logic [data_size-1:0] Mem_Rdata
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
  , output logic [data_size-1:0] Dbg_Checksum
`endif
);

  arb_state_e          state_q, state_d;
  logic [addr_bus-1:0] clr_cnt_q, clr_cnt_d;
  mem_src_e            sel;
  logic                dbg_start_ok;
  logic                fetch, last_acc;
  logic [addr_bus-1:0] fetch_addr;

  // Clear wins over a coincident dump start, which is then dropped.
  assign dbg_start_ok = (state_q == ST_IDLE) && Dbg_Start && !Clr_Start;
  assign Clr_Busy     = (state_q == ST_CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Clr_Start)                         state_d = ST_CLEAR;
        else if (Dbg_Start && Dbg_Len != '0)   state_d = ST_DUMP;
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_DUMP: begin
        if (last_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Strobes are gated by Reset so an aborted clear does not write its current address.
  always_comb begin
    sel = SRC_NONE;
    if (Reset)                      sel = SRC_NONE;
    else if (state_q == ST_CLEAR)   sel = SRC_CLR;
    else if (Cpu_Req)               sel = SRC_CPU;
    else if (fetch)                 sel = SRC_DBG;
  end

  always_comb begin
    Mem_Rd    = 1'b0;
    Mem_Wr    = 1'b0;
    Mem_Addr  = '0;
    Mem_Wdata = '0;
    case (sel)
      SRC_CPU: begin
        Mem_Rd    = !Cpu_Wr;
        Mem_Wr    = Cpu_Wr;
        Mem_Addr  = Cpu_Addr;
        Mem_Wdata = Cpu_Wdata;
      end
      SRC_CLR: begin
        Mem_Wr   = 1'b1;
        Mem_Addr = clr_cnt_q;
      end
      SRC_DBG: begin
        Mem_Rd   = 1'b1;
        Mem_Addr = fetch_addr;
      end
      default: ;
    endcase
  end

  assign Cpu_Ack   = (sel == SRC_CPU);
  assign Cpu_Rdata = (Cpu_Ack && !Cpu_Wr) ? Mem_Rdata : '0;

  dmem_dump_engine #(
    .addr_bus  (addr_bus),
    .data_size (data_size)
  ) u_dump (
    .clk        (Clk),
    .rst        (Reset),
    .start      (dbg_start_ok),
    .active     (state_q == ST_DUMP),
    .cpu_req    (Cpu_Req),
    .base       (Dbg_Base),
    .len        (Dbg_Len),
    .mem_rdata  (Mem_Rdata),
    .dbg_ready  (Dbg_Ready),
    .fetch      (fetch),
    .fetch_addr (fetch_addr),
    .dbg_data   (Dbg_Data),
    .dbg_valid  (Dbg_Valid),
    .dbg_done   (Dbg_Done),
    .last_acc   (last_acc)
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
    , .dbg_checksum (Dbg_Checksum)
`endif
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port memory.
module tb_dmem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Cpu_Req, Cpu_Wr, Cpu_Ack;
  logic [AW-1:0] Cpu_Addr;
  logic [DW-1:0] Cpu_Wdata, Cpu_Rdata;
  logic          Clr_Start, Clr_Busy;
  logic          Dbg_Start, Dbg_Valid, Dbg_Ready, Dbg_Done;
  logic [AW-1:0] Dbg_Base;
  logic [AW:0]   Dbg_Len;
  logic [DW-1:0] Dbg_Data;
  logic          Mem_Rd, Mem_Wr;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Wdata, Mem_Rdata;
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
  logic [DW-1:0] Dbg_Checksum;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) if (Mem_Wr) mem[Mem_Addr] <= Mem_Wdata;
  assign Mem_Rdata = mem[Mem_Addr];

  dmem_port_arbiter #(.addr_bus(AW), .data_size(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cpu_Req(Cpu_Req), .Cpu_Wr(Cpu_Wr), .Cpu_Addr(Cpu_Addr), .Cpu_Wdata(Cpu_Wdata),
    .Cpu_Ack(Cpu_Ack), .Cpu_Rdata(Cpu_Rdata),
    .Clr_Start(Clr_Start), .Clr_Busy(Clr_Busy),
    .Dbg_Start(Dbg_Start), .Dbg_Base(Dbg_Base), .Dbg_Len(Dbg_Len),
    .Dbg_Data(Dbg_Data), .Dbg_Valid(Dbg_Valid), .Dbg_Ready(Dbg_Ready), .Dbg_Done(Dbg_Done),
    .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata)
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
    , .Dbg_Checksum(Dbg_Checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Cpu_Req = 1'b1; Cpu_Wr = 1'b1; Cpu_Addr = a; Cpu_Wdata = d;
    tick;
    Cpu_Req = 1'b0; Cpu_Wr = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = a;
    #1;
    chk({tag, "_ack"}, Cpu_Ack, 1);
    chk(tag, Cpu_Rdata, exp);
    tick;
    Cpu_Req = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    Reset = 1'b1;
    Cpu_Req = 0; Cpu_Wr = 0; Cpu_Addr = '0; Cpu_Wdata = '0;
    Clr_Start = 0; Dbg_Start = 0; Dbg_Base = '0; Dbg_Len = '0; Dbg_Ready = 0;
    tick; tick;

    // Reset state
    chk("rst_busy", Clr_Busy, 0);
    chk("rst_valid", Dbg_Valid, 0);
    chk("rst_done", Dbg_Done, 0);
    chk("rst_data", Dbg_Data, 0);
    chk("rst_strobes", {Mem_Rd, Mem_Wr}, 0);
    chk("rst_addr", Mem_Addr, 0);
    Reset = 1'b0;
    tick;

    // CPU write then read
    Cpu_Req = 1; Cpu_Wr = 1; Cpu_Addr = 11'h005; Cpu_Wdata = 16'hBEEF;
    #1;
    chk("wr_ack", Cpu_Ack, 1);
    chk("wr_strobe", {Mem_Rd, Mem_Wr}, 2'b01);
    chk("wr_addr", Mem_Addr, 11'h005);
    tick;
    Cpu_Wr = 0;
    #1;
    chk("rd_ack", Cpu_Ack, 1);
    chk("rd_data", Cpu_Rdata, 16'hBEEF);
    chk("rd_strobe", {Mem_Rd, Mem_Wr}, 2'b10);
    tick;
    Cpu_Req = 0;
    #1;
    chk("noacc_rdata", Cpu_Rdata, 0);
    chk("noacc_strobe", {Mem_Rd, Mem_Wr}, 0);

    // Full clear with CPU stalled throughout
    cpu_write(11'h7FF, 16'h1234);
    cpu_write(11'h000, 16'h5678);
    Clr_Start = 1;
    tick;
    Clr_Start = 0;
    Cpu_Req = 1; Cpu_Wr = 1; Cpu_Addr = 11'h005; Cpu_Wdata = 16'hFFFF;
    #1;
    chk("clr_first_wr", Mem_Wr, 1);
    chk("clr_first_addr", Mem_Addr, 0);
    chk("clr_first_wdata", Mem_Wdata, 0);
    n = 0; seen = 0;
    while (Clr_Busy && n < 3000) begin
      n++;
      if (Cpu_Ack) seen = 1;
      tick;
    end
    Cpu_Req = 0; Cpu_Wr = 0;
    chk("clr_busy_cycles", n, 2048);
    chk("clr_cpu_stalled", seen, 0);
    cpu_read("clr_rd000", 11'h000, 16'h0);
    cpu_read("clr_rd7ff", 11'h7FF, 16'h0);
    cpu_read("clr_rd005", 11'h005, 16'h0);

    // Dump of 3 words wrapping 0x7FF -> 0x000
    cpu_write(11'h7FE, 16'd1);
    cpu_write(11'h7FF, 16'd2);
    cpu_write(11'h000, 16'd3);
    Dbg_Base = 11'h7FE; Dbg_Len = 12'd3; Dbg_Ready = 1; Dbg_Start = 1;
    tick;
    Dbg_Start = 0;
    chk("d3_fetch0_rd", Mem_Rd, 1);
    chk("d3_fetch0_addr", Mem_Addr, 11'h7FE);
    chk("d3_fetch0_valid", Dbg_Valid, 0);
    tick;
    chk("d3_w0", {Dbg_Valid, Dbg_Data}, {1'b1, 16'd1});
    tick;
    chk("d3_w1", {Dbg_Valid, Dbg_Data}, {1'b1, 16'd2});
    chk("d3_wrap_addr", Mem_Addr, 11'h000);
    tick;
    chk("d3_w2", {Dbg_Valid, Dbg_Data}, {1'b1, 16'd3});
    chk("d3_done_early", Dbg_Done, 0);
    tick;
    chk("d3_done", Dbg_Done, 1);
    chk("d3_valid_off", Dbg_Valid, 0);
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
    chk("d3_checksum", Dbg_Checksum, 16'd6);
`endif
    tick;
    chk("d3_done_pulse", Dbg_Done, 0);

    // Dump of 4 words with backpressure and CPU interleave
    for (int i = 0; i < 4; i++) cpu_write(11'h010 + 11'(i), 16'h00A0 + 16'(i));
    Dbg_Base = 11'h010; Dbg_Len = 12'd4; Dbg_Ready = 1; Dbg_Start = 1;
    tick;
    Dbg_Start = 0;
    chk("d4_fetch0", {Mem_Rd, Mem_Addr}, {1'b1, 11'h010});
    tick;
    Dbg_Ready = 0; Cpu_Req = 1; Cpu_Wr = 0; Cpu_Addr = 11'h005;
    #1;
    chk("d4_w0", {Dbg_Valid, Dbg_Data}, {1'b1, 16'h00A0});
    chk("d4_cpu_rd_ack", Cpu_Ack, 1);
    chk("d4_cpu_rd_addr", Mem_Addr, 11'h005);
    tick;
    Cpu_Req = 0;
    #1;
    chk("d4_hold", {Dbg_Valid, Dbg_Data}, {1'b1, 16'h00A0});
    chk("d4_hold_noread", Mem_Rd, 0);
    tick;
    Dbg_Ready = 1;
    #1;
    chk("d4_hold2", Dbg_Data, 16'h00A0);
    chk("d4_fetch1", {Mem_Rd, Mem_Addr}, {1'b1, 11'h011});
    tick;
    Cpu_Req = 1; Cpu_Wr = 1; Cpu_Addr = 11'h020; Cpu_Wdata = 16'h5555;
    #1;
    chk("d4_w1", {Dbg_Valid, Dbg_Data}, {1'b1, 16'h00A1});
    chk("d4_cpu_wr_ack", Cpu_Ack, 1);
    chk("d4_cpu_wr_mem", {Mem_Wr, Mem_Addr}, {1'b1, 11'h020});
    tick;
    Cpu_Req = 0; Cpu_Wr = 0;
    #1;
    chk("d4_empty", Dbg_Valid, 0);
    chk("d4_fetch2", {Mem_Rd, Mem_Addr}, {1'b1, 11'h012});
    tick;
    chk("d4_w2", {Dbg_Valid, Dbg_Data}, {1'b1, 16'h00A2});
    tick;
    chk("d4_w3", {Dbg_Valid, Dbg_Data}, {1'b1, 16'h00A3});
    chk("d4_done_early", Dbg_Done, 0);
    tick;
    chk("d4_done", {Dbg_Done, Dbg_Valid}, 2'b10);
`ifdef DMEM_ARB_DUMP_CHECKSUM_EN
    chk("d4_checksum", Dbg_Checksum, 16'h0286);
`endif
    Dbg_Ready = 0;
    tick;
    cpu_read("d4_cpu_wrote", 11'h020, 16'h5555);

    // Clear and dump start together: clear wins, dump dropped
    Dbg_Base = 11'h000; Dbg_Len = 12'd2; Dbg_Ready = 1;
    Clr_Start = 1; Dbg_Start = 1;
    tick;
    Clr_Start = 0; Dbg_Start = 0;
    n = 0; seen = 0;
    while (Clr_Busy && n < 3000) begin
      n++;
      if (Dbg_Valid || Dbg_Done || Mem_Rd) seen = 1;
      tick;
    end
    chk("both_clr_cycles", n, 2048);
    chk("both_no_dump", seen, 0);
    tick;
    chk("both_after", {Dbg_Valid, Dbg_Done}, 0);

    // Zero-length dump
    Dbg_Len = '0; Dbg_Start = 1;
    #1;
    chk("len0_noread", Mem_Rd, 0);
    tick;
    Dbg_Start = 0;
    chk("len0_done", Dbg_Done, 1);
    chk("len0_novalid", {Dbg_Valid, Mem_Rd}, 0);
    tick;
    chk("len0_done_pulse", Dbg_Done, 0);
    Dbg_Ready = 0;

    // Reset 100 cycles into a clear
    cpu_write(11'h032, 16'h1111);
    cpu_write(11'h063, 16'h2222);
    cpu_write(11'h064, 16'hCAFE);
    Clr_Start = 1;
    tick;
    Clr_Start = 0;
    repeat (100) tick;
    chk("rstclr_addr", Mem_Addr, 11'h064);
    chk("rstclr_busy", Clr_Busy, 1);
    Reset = 1;
    #1;
    chk("rstclr_nowr", Mem_Wr, 0);
    tick;
    chk("rstclr_busy_off", Clr_Busy, 0);
    Reset = 0;
    cpu_read("rstclr_032", 11'h032, 16'h0);
    cpu_read("rstclr_063", 11'h063, 16'h0);
    cpu_read("rstclr_064", 11'h064, 16'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
